// File: rtl/serial_adder16.sv
// rtl/serial_adder16.sv - nibble-serial W-bit adder built around one time-multiplexed 4-bit ripple adder
// Operands are latched on accept, summed LS nibble first, and the result is held until consumed.

module fulladder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_bit
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = c[4];

endmodule

module serial_adder16 #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         carry_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    localparam int         CW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic [W-1:0]  sum_nxt;
    logic [CW-1:0] cnt;
    logic          carry_q;
    logic          cout_q;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    nib_sum;
    logic          nib_cout;

    fulladder4 u_fa (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (nib_sum),
        .cout (nib_cout)
    );

    // Nibble select and result merge for the current counter position.
    always_comb begin
        a_nib   = '0;
        b_nib   = '0;
        sum_nxt = sum_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                a_nib            = a_q[4*i +: 4];
                b_nib            = b_q[4*i +: 4];
                sum_nxt[4*i +: 4] = nib_sum;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // carry_q chains nibbles; cout_q is the visible carry so it moves only on ADD cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid_i) begin
                a_q     <= a_i;
                b_q     <= b_i;
                carry_q <= carry_i;
                cnt     <= '0;
            end else if (state == ADD) begin
                sum_q   <= sum_nxt;
                carry_q <= nib_cout;
                cout_q  <= nib_cout;
                if (cnt != LAST) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = cout_q;

endmodule

// File: doc/serial_adder16.md
SERIAL_ADDER16 -- requirements
Module: serial_adder16

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid_i  input  1  operand request valid.
REQ-005 in_ready_o  output  1  block can accept an operand request.
REQ-006 a_i  input  W  operand A, unsigned.
REQ-007 b_i  input  W  operand B, unsigned.
REQ-008 carry_i  input  1  carry-in for the least-significant nibble.
REQ-009 out_valid_o  output  1  result valid.
REQ-010 out_ready_i  input  1  consumer accepts result.
REQ-011 sum_o  output  W  result sum (a_i + b_i + carry_i) mod 2^W.
REQ-012 carry_o  output  1  carry-out of the most-significant nibble.

Function
REQ-013 Arithmetic SHALL use exactly one instance of the team's 4-bit ripple adder (fulladder4), time-multiplexed one nibble per cycle, least-significant nibble first.
REQ-014 FSM states SHALL be IDLE, ADD, DONE; no other reachable states.
REQ-015 IDLE: in_ready_o=1, out_valid_o=0; on in_valid_i=1 the block SHALL latch a_i, b_i, carry_i into internal registers, clear nibble counter to 0, go to ADD.
REQ-016 ADD: in_ready_o=0, out_valid_o=0; each cycle the adder SHALL see A[4k+3:4k], B[4k+3:4k] and the carry register, where k = counter.
REQ-017 ADD: each cycle the adder sum nibble SHALL be written into result bits [4k+3:4k] and the adder carry-out into the carry register; counter increments.
REQ-018 ADD: on the cycle k = NIBBLES-1 the block SHALL go to DONE; counter never exceeds NIBBLES-1.
REQ-019 Latency: request accepted at edge T SHALL produce out_valid_o=1 after edge T+NIBBLES (exactly NIBBLES ADD cycles).
REQ-020 DONE: out_valid_o=1, in_ready_o=0, sum_o and carry_o SHALL hold constant until out_ready_i=1.
REQ-021 DONE with out_ready_i=1: result consumed at that edge, go to IDLE; next request accepted no earlier than the following cycle (no back-to-back overlap).
REQ-022 in_valid_i and operand changes while in ADD or DONE SHALL be ignored; latched operands are unaffected.
REQ-023 out_ready_i outside DONE SHALL have no effect.
REQ-024 sum_o and carry_o SHALL change only on ADD cycles; values outside DONE are don't-care for the consumer but SHALL not be X after reset.
REQ-025 Carry chaining SHALL be full W-bit exact: carry_o = bit W of the (W+1)-bit sum of a_i + b_i + carry_i.

Reset
REQ-026 rst_n_i=0 SHALL immediately (asynchronously) force state IDLE, counter 0, carry register 0, operand and result registers 0.
REQ-027 During and after reset: in_ready_o=1, out_valid_o=0, sum_o=0, carry_o=0.
REQ-028 Reset asserted mid-ADD or in DONE SHALL abort the operation; no partial result is ever presented with out_valid_o=1.
REQ-029 First request after reset release SHALL be accepted on the first rising edge with rst_n_i=1 and in_valid_i=1.

Verification (NIBBLES=4)
REQ-030 a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid 4 edges after accept, sum=0x5555, carry=0, then IDLE.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1 (carry propagates through all four nibble steps).
REQ-032 a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, carry=1; a=0x0000, b=0x0000, cin=1 -> sum=0x0001, carry=0.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/carry stable, in_ready stays 0; out_ready=1 -> IDLE next edge.
REQ-034 Busy ignore: second in_valid with different operands during ADD -> first result unchanged, second request not accepted until in_ready=1.
REQ-035 Reset mid-ADD (after 2 nibbles) -> in_ready=1, out_valid=0, sum=0 immediately; fresh request then completes correctly.
REQ-036 Random: 10k random operand/cin/out_ready sequences checked against a W+1-bit reference sum; zero mismatches.
